// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// and an external loader/debug port, with starvation-bounded EXT windows.
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int EXT_BURST    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [XLEN/8-1:0]     cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [XLEN-1:0]       cpu_wd,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  ext_we,
  input  logic [XLEN/8-1:0]     ext_be,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [XLEN-1:0]       ext_wd,
  output logic                  ext_rvalid,
  output logic [XLEN-1:0]       ext_rdata,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wd,
  input  logic [XLEN-1:0]       mem_rd
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(EXT_BURST + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(EXT_BURST - 1);

  typedef enum logic {
    CPU_PRI,
    EXT_PRI
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic [BW-1:0] burst_q;
  logic [BW-1:0] burst_d;
  logic          ext_hs;
  logic          ext_rd_hs;

  // Same-cycle grant: priority owner wins, the other only gets an idle slot
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_ready = 1'b0;
    case (state_q)
      CPU_PRI: begin
        cpu_gnt   = cpu_req;
        ext_ready = ext_valid && !cpu_req;
      end
      EXT_PRI: begin
        ext_ready = ext_valid;
        cpu_gnt   = cpu_req && !ext_valid;
      end
    endcase
  end

  assign cpu_stall = cpu_req && !cpu_gnt;
  assign ext_hs    = ext_valid && ext_ready;
  assign ext_rd_hs = ext_hs && !ext_we;

  // Route the granted requester to the memory; idle bus is all zeros
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = '0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_be   = cpu_be;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (ext_ready) begin
      mem_we   = ext_we;
      mem_be   = ext_be;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end
  end

  // Next state: starvation opens an EXT window, the burst count closes it
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    case (state_q)
      CPU_PRI: begin
        burst_d = '0;
        if (ext_valid && !ext_ready) begin
          if (starve_q == STARVE_LAST) begin
            state_d  = EXT_PRI;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      EXT_PRI: begin
        starve_d = '0;
        if (!ext_valid) begin
          state_d = CPU_PRI;
          burst_d = '0;
        end else if (burst_q == BURST_LAST) begin
          state_d = CPU_PRI;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CPU_PRI;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // EXT read return: one-cycle registered pulse, data held between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_rd_hs;
      if (ext_rd_hs) begin
        ext_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus a cycle-level reference model
// of the arbitration rules, checked at every falling edge.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
  localparam int BURST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wd;
  logic        cpu_gnt, cpu_stall;
  logic        ext_valid, ext_ready, ext_we;
  logic [3:0]  ext_be;
  logic [7:0]  ext_addr;
  logic [31:0] ext_wd;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] tbmem [0:63];

  dmem_arbiter #(
    .XLEN(32), .ADDR_WIDTH(8),
    .STARVE_LIMIT(LIMIT), .EXT_BURST(BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_be(ext_be), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = tbmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) tbmem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_ext = 0, n_ext = 0;
  int          m_starve = 0, n_starve = 0;
  int          m_burst = 0, n_burst = 0;
  bit          m_rv = 0, n_rv = 0;
  logic [31:0] m_rd = 0, n_rd = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ext <= 0; m_starve <= 0; m_burst <= 0; m_rv <= 0; m_rd <= 0;
    end else begin
      m_ext <= n_ext; m_starve <= n_starve; m_burst <= n_burst;
      m_rv <= n_rv; m_rd <= n_rd;
    end
  end

  always @(negedge clk) begin
    bit e_cg, e_er, hs;
    logic        e_we;
    logic [3:0]  e_be;
    logic [7:0]  e_ad;
    logic [31:0] e_wd;
    e_cg = m_ext ? (cpu_req && !ext_valid) : cpu_req;
    e_er = m_ext ? ext_valid : (ext_valid && !cpu_req);
    e_we = 0; e_be = 0; e_ad = 0; e_wd = 0;
    if (e_cg) begin
      e_we = cpu_we; e_be = cpu_be; e_ad = cpu_addr; e_wd = cpu_wd;
    end else if (e_er) begin
      e_we = ext_we; e_be = ext_be; e_ad = ext_addr; e_wd = ext_wd;
    end
    chk("m_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cg});
    chk("m_ext_ready", {31'd0, ext_ready}, {31'd0, e_er});
    chk("m_cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !e_cg});
    chk("m_mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("m_mem_be", {28'd0, mem_be}, {28'd0, e_be});
    chk("m_mem_addr", {24'd0, mem_addr}, {24'd0, e_ad});
    chk("m_mem_wd", mem_wd, e_wd);
    chk("m_rvalid", {31'd0, ext_rvalid}, {31'd0, m_rv});
    chk("m_rdata", ext_rdata, m_rd);
    hs = ext_valid && e_er;
    n_ext = m_ext; n_starve = m_starve; n_burst = m_burst;
    n_rv = hs && !ext_we;
    n_rd = n_rv ? tbmem[ext_addr[7:2]] : m_rd;
    if (!m_ext) begin
      if (ext_valid && !hs) begin
        n_starve = m_starve + 1;
        if (n_starve == LIMIT) begin
          n_ext = 1; n_starve = 0; n_burst = 0;
        end
      end else begin
        n_starve = 0;
      end
    end else begin
      n_starve = 0;
      if (!ext_valid) begin
        n_ext = 0;
      end else begin
        n_burst = m_burst + 1;
        if (n_burst == BURST) n_ext = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wd = 0;
    ext_valid = 0; ext_we = 0; ext_be = 0; ext_addr = 0; ext_wd = 0;
  endtask

  initial begin
    bit e;
    for (int i = 0; i < 64; i++) tbmem[i] = 32'h0;
    tbmem[4] = 32'hDEADBEEF;
    reset = 1;
    idle();
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_rdata", ext_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    nxt();
    reset = 0;

    // CPU-only traffic
    cpu_req = 1; cpu_we = 1; cpu_be = 4'hF;
    cpu_addr = 8'h04; cpu_wd = 32'h11223344;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
      chk("t1_we", {31'd0, mem_we}, 32'd1);
      chk("t1_addr", {24'd0, mem_addr}, 32'h04);
      nxt();
    end
    idle();
    nxt();

    // EXT-only read
    ext_valid = 1; ext_addr = 8'h10;
    @(negedge clk);
    chk("t2_ready", {31'd0, ext_ready}, 32'd1);
    nxt();
    idle();
    @(negedge clk);
    chk("t2_rvalid", {31'd0, ext_rvalid}, 32'd1);
    chk("t2_rdata", ext_rdata, 32'hDEADBEEF);
    nxt();
    @(negedge clk);
    chk("t2_rvalid_off", {31'd0, ext_rvalid}, 32'd0);
    nxt();

    // Contention: EXT wins cycles 4,5,10,11
    cpu_req = 1; ext_valid = 1; ext_addr = 8'h10;
    for (int c = 0; c < 12; c++) begin
      e = (c == 4) || (c == 5) || (c == 10) || (c == 11);
      @(negedge clk);
      chk($sformatf("t3_cpu_gnt_c%0d", c), {31'd0, cpu_gnt}, {31'd0, !e});
      chk($sformatf("t3_ext_rdy_c%0d", c), {31'd0, ext_ready}, {31'd0, e});
      chk($sformatf("t3_stall_c%0d", c), {31'd0, cpu_stall}, {31'd0, e});
      nxt();
    end
    idle();
    nxt();

    // Early exit after one handshake in the window
    cpu_req = 1; ext_valid = 1; ext_addr = 8'h10;
    for (int c = 0; c < 12; c++) begin
      if (c == 5 || c == 11) ext_valid = 0;
      if (c == 6) ext_valid = 1;
      e = (c == 4) || (c == 10);
      @(negedge clk);
      chk($sformatf("t4_ext_rdy_c%0d", c), {31'd0, ext_ready}, {31'd0, e});
      chk($sformatf("t4_stall_c%0d", c), {31'd0, cpu_stall}, {31'd0, e});
      nxt();
    end
    idle();
    nxt();

    // EXT write, then read it back
    ext_valid = 1; ext_we = 1; ext_be = 4'b0011;
    ext_addr = 8'h20; ext_wd = 32'h0000ABCD;
    @(negedge clk);
    chk("t5_ready", {31'd0, ext_ready}, 32'd1);
    chk("t5_we", {31'd0, mem_we}, 32'd1);
    chk("t5_be", {28'd0, mem_be}, 32'h3);
    chk("t5_addr", {24'd0, mem_addr}, 32'h20);
    chk("t5_wd", mem_wd, 32'h0000ABCD);
    nxt();
    idle();
    @(negedge clk);
    chk("t5_no_rvalid", {31'd0, ext_rvalid}, 32'd0);
    nxt();
    ext_valid = 1; ext_addr = 8'h20;
    nxt();
    idle();
    @(negedge clk);
    chk("t5_readback", ext_rdata, 32'h0000ABCD);
    nxt();

    // Async reset mid-window with rvalid pending
    cpu_req = 1; ext_valid = 1; ext_addr = 8'h10;
    for (int c = 0; c < 5; c++) nxt();
    chk("t6_rvalid_pre", {31'd0, ext_rvalid}, 32'd1);
    chk("t6_ext_pri", {31'd0, ext_ready}, 32'd1);
    #2;
    reset = 1;
    #1;
    chk("t6_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("t6_rdata", ext_rdata, 32'd0);
    chk("t6_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("t6_ext_rdy", {31'd0, ext_ready}, 32'd0);
    nxt();
    reset = 0;
    idle();
    nxt();
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port, valid/ready handshake).
- The CPU has default priority.
- A starvation counter forces a bounded EXT window, during which the CPU is stalled.
- The block sits between the MEM-stage byte-enable/store logic and the data memory. It feeds the CPU stall request to the hazard unit.

Parameters:
XLEN, 32, data width in bits
ADDR_WIDTH, 8, data memory byte-address width
STARVE_LIMIT, 4, consecutive denied EXT cycles before forced EXT priority (range >=1)
EXT_BURST, 2, maximum EXT grants per forced window (range >=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cpu_req  in  1  MEM stage requests memory (load or store)
cpu_we  in  1  CPU write enable
cpu_be  in  XLEN/8  CPU byte enables
cpu_addr  in  ADDR_WIDTH  CPU byte address
cpu_wd  in  XLEN  CPU write data
cpu_gnt  out  1  CPU owns memory this cycle
cpu_stall  out  1  cpu_req && !cpu_gnt; goes to the hazard unit
ext_valid  in  1  EXT request valid
ext_ready  out  1  EXT granted this cycle
ext_we  in  1  EXT write enable
ext_be  in  XLEN/8  EXT byte enables
ext_addr  in  ADDR_WIDTH  EXT byte address
ext_wd  in  XLEN  EXT write data
ext_rvalid  out  1  EXT read data valid (registered)
ext_rdata  out  XLEN  EXT read data (registered)
mem_we  out  1  to dmem we
mem_be  out  XLEN/8  to dmem byteEnable
mem_addr  out  ADDR_WIDTH  to dmem address
mem_wd  out  XLEN  to dmem wd
mem_rd  in  XLEN  from dmem rd (combinational read)

Behaviour:
- The clock port is clk. Reset is asynchronous and active-high, on port reset.
- FSM states:
  - CPU_PRI (reset state).
  - EXT_PRI.
- Grant, combinational in the same cycle:
  - In CPU_PRI: cpu_gnt = cpu_req; ext_ready = ext_valid && !cpu_req.
  - In EXT_PRI: ext_ready = ext_valid; cpu_gnt = cpu_req && !ext_valid.
  - cpu_gnt and ext_ready are never both 1.
- Handshake:
  - An EXT transfer occurs on ext_valid && ext_ready.
  - EXT must hold its address, data and control stable while ext_valid && !ext_ready.
  - ext_ready never depends on a registered version of ext_valid.
- Memory mux:
  - The granted requester's we/be/addr/wd drive the mem_* outputs.
  - With no grant: mem_we=0, mem_be=0, mem_addr=0, mem_wd=0.
  - mem_we is never 1 without a grant.
- CPU reads: mem_rd is used by the MEM stage in the same cycle. The block adds no latency on the CPU path.
- EXT reads:
  - On an EXT read handshake (ext_we=0), ext_rdata <= mem_rd and ext_rvalid <= 1 on the next edge.
  - Otherwise ext_rvalid <= 0, and ext_rdata holds its value.
  - An EXT write never raises ext_rvalid.
  - Back-to-back EXT reads give back-to-back rvalid pulses.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - In CPU_PRI, a cycle with ext_valid && !ext_ready increments the counter.
  - If ext_valid is 0, or an EXT handshake occurs, the counter clears to 0.
  - When a denied cycle brings the counter to STARVE_LIMIT, next state = EXT_PRI and the counter clears.
- Burst counter (width $clog2(EXT_BURST+1)):
  - Counts EXT handshakes in EXT_PRI.
  - Returns to CPU_PRI on the edge after the EXT_BURST-th handshake, or after any EXT_PRI cycle with ext_valid=0.
  - It clears on every entry to EXT_PRI.
- Simultaneous events:
  - CPU idle in EXT_PRI: EXT is still counted against the burst.
  - A cpu_req arriving in the same cycle as the forced window starts: the CPU stalls.
- Reset, applied asynchronously at any time, including mid-window and with a pending rvalid:
  - state=CPU_PRI, both counters=0, ext_rvalid=0, ext_rdata=0.
  - Combinational outputs follow the CPU_PRI rules immediately.
- Widths: addresses pass through unmodified. There is no alignment check; the byte-enable logic upstream owns alignment.

Test Plan:
1. CPU-only traffic: cpu_req=1 every cycle, ext_valid=0, cpu_we=1, cpu_be=4'b1111, cpu_addr=0x04 -> cpu_gnt=1, cpu_stall=0, mem_we=1, mem_addr=0x04, state stays CPU_PRI.
2. EXT-only read: memory[0x10]=0xDEADBEEF, ext_valid=1 for one cycle with ext_we=0, ext_addr=0x10 -> ext_ready=1 in the same cycle; next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF; the cycle after that, ext_rvalid=0.
3. Contention with defaults (STARVE_LIMIT=4, EXT_BURST=2), cpu_req and ext_valid held high from cycle 0 -> CPU granted cycles 0-3; EXT granted cycles 4-5 with cpu_stall=1; CPU granted cycles 6-9; EXT granted again at cycles 10-11.
4. Early exit: in EXT_PRI, ext_valid drops after 1 handshake -> back to CPU_PRI next cycle, starvation counter=0, cpu_stall=0.
5. EXT write: ext_we=1, ext_be=4'b0011, ext_addr=0x20, ext_wd=0x0000ABCD, CPU idle -> mem_we=1, mem_be=4'b0011, mem_addr=0x20, mem_wd=0x0000ABCD; ext_rvalid remains 0.
6. Asynchronous reset asserted mid-cycle while in EXT_PRI with ext_rvalid=1 -> ext_rvalid=0, ext_rdata=0 and state=CPU_PRI immediately, before the next clk edge; a held cpu_req then sees cpu_gnt=1.
